// File: rtl/fifo_dp_ram_pipelined.sv
// Single-clock FIFO on an inferred simple dual-port RAM.
// Read data comes out of a LATENCY-deep pipeline and is qualified by read_valid.
// Occupancy and all status flags are registered. The overflow and underflow
// flags are sticky until clear_errors.
module fifo_dp_ram_pipelined #(
  parameter int FIFO_DEPTH         = 32,
  parameter int FIFO_DATA_WIDTH    = 8,
  parameter int ALMOST_FULL_DEPTH  = 3,
  parameter int ALMOST_EMPTY_DEPTH = 3,
  parameter int LATENCY            = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         write,
  input  logic [FIFO_DATA_WIDTH-1:0]   write_data,
  input  logic                         read,
  output logic [FIFO_DATA_WIDTH-1:0]   read_data,
  output logic                         read_valid,
  output logic [$clog2(FIFO_DEPTH):0]  used,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_empty,
  output logic                         almost_full,
  input  logic                         clear_errors,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int UW     = ADDR_W + 1;

  localparam logic [ADDR_W:0] C_DEPTH    = UW'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] C_AF_LEVEL = UW'(FIFO_DEPTH - ALMOST_FULL_DEPTH);
  localparam logic [ADDR_W:0] C_AE_LEVEL = UW'(ALMOST_EMPTY_DEPTH);

  // Refuse to build with a depth the wrapping pointers cannot address cleanly,
  // or with a pipeline length outside the supported range.
  if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_dp_ram_pipelined: FIFO_DEPTH must be a power of two >= 4");
  end
  if ((LATENCY < 1) || (LATENCY > 8)) begin : g_bad_latency
    $error("fifo_dp_ram_pipelined: LATENCY must be within 1..8");
  end

  logic [FIFO_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

  // The pointer MSB is the wrap flag. The low bits address the RAM.
  logic [ADDR_W:0] r_wptr;
  logic [ADDR_W:0] r_rptr;
  logic [ADDR_W:0] r_used;
  logic            r_empty;
  logic            r_full;
  logic            r_almost_empty;
  logic            r_almost_full;
  logic            r_overflow;
  logic            r_underflow;

  logic [FIFO_DATA_WIDTH-1:0] r_data [LATENCY];
  logic [LATENCY-1:0]         r_valid;

  logic            w_wr_ok;
  logic            w_rd_ok;
  logic [ADDR_W:0] w_wptr_next;
  logic [ADDR_W:0] w_rptr_next;
  logic [ADDR_W:0] w_used_next;

  // Acceptance looks only at the registered flags. This means there is no
  // write-while-full passthrough and no read-while-empty bypass.
  assign w_wr_ok     = write & ~r_full;
  assign w_rd_ok     = read  & ~r_empty;
  assign w_wptr_next = r_wptr + UW'(w_wr_ok);
  assign w_rptr_next = r_rptr + UW'(w_rd_ok);
  assign w_used_next = w_wptr_next - w_rptr_next;

  // Advance the pointers. Occupancy and flags are registered from the next
  // occupancy, so they all change in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_used         <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_empty <= 1'b1;
      r_almost_full  <= 1'b0;
    end else begin
      r_wptr         <= w_wptr_next;
      r_rptr         <= w_rptr_next;
      r_used         <= w_used_next;
      r_empty        <= (w_used_next == '0);
      r_full         <= (w_used_next == C_DEPTH);
      r_almost_empty <= (w_used_next <= C_AE_LEVEL);
      r_almost_full  <= (w_used_next >= C_AF_LEVEL);
    end
  end

  // The RAM write port. Storage has no reset, so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wptr[ADDR_W-1:0]] <= write_data;
    end
  end

  // Read pipeline. Stage 0 is the registered RAM output. Each stage loads
  // only when a valid word arrives, so the last stage holds its value between
  // valid words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_valid[0] <= w_rd_ok;
      if (w_rd_ok) begin
        r_data[0] <= r_mem[r_rptr[ADDR_W-1:0]];
      end
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        if (r_valid[i-1]) begin
          r_data[i] <= r_data[i-1];
        end
      end
    end
  end

  // Sticky error flags. A new error event takes priority over a clear in the
  // same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (write & r_full) begin
        r_overflow <= 1'b1;
      end else if (clear_errors) begin
        r_overflow <= 1'b0;
      end
      if (read & r_empty) begin
        r_underflow <= 1'b1;
      end else if (clear_errors) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign read_data    = r_data[LATENCY-1];
  assign read_valid   = r_valid[LATENCY-1];
  assign used         = r_used;
  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_almost_empty;
  assign almost_full  = r_almost_full;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_dp_ram_pipelined.sv
// Testbench for fifo_dp_ram_pipelined.
// A queue-based reference model predicts occupancy, flags, and the read stream.
// Returned words are held in a list of (due edge, word) pairs.
module tb_fifo_dp_ram_pipelined;

  localparam int DEPTH = 32;
  localparam int DW    = 8;
  localparam int AFD   = 3;
  localparam int AED   = 3;
  localparam int LAT   = 3;

  typedef struct {
    int          due;
    logic [DW-1:0] d;
  } pend_t;

  logic                     clk;
  logic                     reset;
  logic                     write;
  logic [DW-1:0]            write_data;
  logic                     read;
  logic [DW-1:0]            read_data;
  logic                     read_valid;
  logic [$clog2(DEPTH):0]   used;
  logic                     empty;
  logic                     full;
  logic                     almost_empty;
  logic                     almost_full;
  logic                     clear_errors;
  logic                     overflow;
  logic                     underflow;

  int            checks;
  int            failures;
  int            edgeNum;
  logic [DW-1:0] q [$];
  pend_t         pend [$];
  logic [DW-1:0] lastData;
  logic          expValid;
  logic          expOvf;
  logic          expUnf;
  int            validCount;

  fifo_dp_ram_pipelined #(
    .FIFO_DEPTH        (DEPTH),
    .FIFO_DATA_WIDTH   (DW),
    .ALMOST_FULL_DEPTH (AFD),
    .ALMOST_EMPTY_DEPTH(AED),
    .LATENCY           (LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .write       (write),
    .write_data  (write_data),
    .read        (read),
    .read_data   (read_data),
    .read_valid  (read_valid),
    .used        (used),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .clear_errors(clear_errors),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value with its expected value. Count the check, and count and
  // report any failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edgeNum);
    end
  endtask

  // Compare every output with the model's view of the current cycle.
  task automatic checkAll();
    int n;
    n = q.size();
    checkOutput("used", 32'(used), n);
    checkOutput("empty", 32'(empty), 32'(n == 0));
    checkOutput("full", 32'(full), 32'(n == DEPTH));
    checkOutput("almost_empty", 32'(almost_empty), 32'(n <= AED));
    checkOutput("almost_full", 32'(almost_full), 32'(n >= DEPTH - AFD));
    checkOutput("read_valid", 32'(read_valid), 32'(expValid));
    checkOutput("read_data", 32'(read_data), 32'(lastData));
    checkOutput("overflow", 32'(overflow), 32'(expOvf));
    checkOutput("underflow", 32'(underflow), 32'(expUnf));
  endtask

  // Drive one cycle of requests and let the model accept or reject them from
  // its pre-edge state. Then check the outputs just after the edge.
  task automatic applyStimulus(input logic w, input logic [DW-1:0] wd, input logic r, input logic clr);
    logic isFull;
    logic isEmpty;
    pend_t p;
    isFull       = (q.size() == DEPTH);
    isEmpty      = (q.size() == 0);
    write        = w;
    write_data   = wd;
    read         = r;
    clear_errors = clr;
    @(posedge clk);
    edgeNum++;
    #1;
    if (r && !isEmpty) begin
      p.due = edgeNum + LAT - 1;
      p.d   = q.pop_front();
      pend.push_back(p);
    end
    if (w && !isFull) q.push_back(wd);
    if (w && isFull) expOvf = 1'b1;
    else if (clr) expOvf = 1'b0;
    if (r && isEmpty) expUnf = 1'b1;
    else if (clr) expUnf = 1'b0;
    expValid = 1'b0;
    if (pend.size() > 0 && pend[0].due == edgeNum) begin
      expValid = 1'b1;
      lastData = pend[0].d;
      void'(pend.pop_front());
      validCount++;
    end
    write        = 1'b0;
    read         = 1'b0;
    clear_errors = 1'b0;
    checkAll();
  endtask

  // Assert reset asynchronously. Check immediately, hold for one edge, then release.
  task automatic doReset();
    reset = 1'b1;
    #1;
    q.delete();
    pend.delete();
    lastData = '0;
    expValid = 1'b0;
    expOvf   = 1'b0;
    expUnf   = 1'b0;
    checkAll();
    @(posedge clk);
    edgeNum++;
    #1;
    checkAll();
    reset = 1'b0;
  endtask

  // Idle until all in-flight reads have come out.
  task automatic drainPipe();
    for (int i = 0; i < LAT + 1; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    edgeNum      = 0;
    validCount   = 0;
    lastData     = '0;
    expValid     = 1'b0;
    expOvf       = 1'b0;
    expUnf       = 1'b0;
    reset        = 1'b1;
    write        = 1'b0;
    write_data   = '0;
    read         = 1'b0;
    clear_errors = 1'b0;

    // Reset state, then fill past full with 0..39.
    #2;
    doReset();
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, DW'(i), 1'b0, 1'b0);
    checkOutput("fill_used32", 32'(used), 32);
    checkOutput("fill_overflow", 32'(overflow), 1);

    // Drain with 40 reads. Expect 32 valid words in order, then underflow.
    validCount = 0;
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    drainPipe();
    checkOutput("drain_valid_count", validCount, 32);
    checkOutput("drain_last_word", 32'(read_data), 31);
    checkOutput("drain_underflow", 32'(underflow), 1);

    // Second lap with 32..63 exercises the pointer wrap flag. Then clear the errors.
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, DW'(32 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    drainPipe();
    checkOutput("wrap_last_word", 32'(read_data), 63);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("clear_overflow", 32'(overflow), 0);
    checkOutput("clear_underflow", 32'(underflow), 0);

    // Preload three words, then stream simultaneous read and write.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(48 + i), 1'b0, 1'b0);
    validCount = 0;
    for (int i = 0; i < 67; i++) applyStimulus(1'b1, DW'(51 + i), 1'b1, 1'b0);
    checkOutput("stream_used3", 32'(used), 3);
    checkOutput("stream_valid_count", validCount, 67 - LAT + 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    drainPipe();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // From empty, paired read and write with two idle cycles between pairs.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, DW'(128 + i), 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
    end
    checkOutput("gap_underflow", 32'(underflow), 1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    drainPipe();
    checkOutput("gap_last_word", 32'(read_data), 135);

    // Reset with reads in flight. Those words must never come out.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, DW'(200 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    doReset();
    drainPipe();
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    drainPipe();
    checkOutput("post_reset_word", 32'(read_data), 32'h A5);

    // Randomised traffic: first write-biased to reach full, then read-biased.
    for (int i = 0; i < 500; i++) begin
      int wp;
      wp = (i < 250) ? 70 : 30;
      applyStimulus(($urandom_range(0, 99) < wp), DW'($urandom),
                    ($urandom_range(0, 99) < (100 - wp)),
                    ($urandom_range(0, 99) < 5));
    end
    drainPipe();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_dp_ram_pipelined.md
Name: fifo_dp_ram_pipelined

Overview:
Synchronous single-clock FIFO built on an inferred simple dual-port RAM. It has a parametrised read-data pipeline with a read_valid qualifier, an occupancy count output, and sticky overflow/underflow error flags with a clear input. It is the generalised successor of the team's simple DP-RAM FIFO. It sits between stream producers and consumers in the ChipExpo datapath, wherever rate decoupling with known read latency is required.

Parameters:
FIFO_DEPTH, 32, number of entries; must be a power of two, >= 4.
FIFO_DATA_WIDTH, 8, width of each entry in bits.
ALMOST_FULL_DEPTH, 3, almost_full asserts when free entries <= this value.
ALMOST_EMPTY_DEPTH, 3, almost_empty asserts when used entries <= this value.
LATENCY, 3, cycles from an accepted read to read_valid/read_data; legal range 1..8.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-high reset.
write  in  1  write request.
write_data  in  FIFO_DATA_WIDTH  data to write.
read  in  1  read request.
read_data  out  FIFO_DATA_WIDTH  read data, qualified by read_valid.
read_valid  out  1  read_data holds the word of a read accepted LATENCY cycles earlier.
used  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
empty  out  1  used == 0.
full  out  1  used == FIFO_DEPTH.
almost_empty  out  1  used <= ALMOST_EMPTY_DEPTH.
almost_full  out  1  used >= FIFO_DEPTH-ALMOST_FULL_DEPTH.
clear_errors  in  1  synchronous clear of overflow/underflow.
overflow  out  1  sticky: write attempted while full.
underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: used=0, empty=1, full=0, almost_empty=1, almost_full=0, read_valid=0, read_data=0, overflow=0, underflow=0.
- Reset pointers: write and read pointers = 0.
- Reset pipeline: the entire read pipeline is flushed. Reset asserted mid-operation discards all stored and in-flight words; read_valid is 0 from reset assertion onward.
- RAM contents are not reset.
- Pointers: ADDR_W+1 bits, where ADDR_W = $clog2(FIFO_DEPTH). The MSB is the wrap flag. Low bits address the RAM; pointers wrap naturally from FIFO_DEPTH-1 to 0 with the MSB toggling.
- Write acceptance: wr_ok = write & ~full.
  - Accepted: RAM[wptr] <= write_data; wptr increments.
  - Rejected (write & full): overflow set to 1; FIFO state unchanged.
- Read acceptance: rd_ok = read & ~empty.
  - Accepted: rptr increments; the word at the old rptr enters the read pipeline.
  - Rejected (read & empty): underflow set to 1; nothing enters the pipeline.
- Flag decisions use the registered flags only. A write while full is rejected even if a read is accepted in the same cycle. A read while empty is rejected even if a write is accepted in the same cycle (no bypass).
- Occupancy: used += wr_ok - rd_ok at each edge. Simultaneous accepted read and write leave used unchanged.
- Flag updates: all flags are registered, derived from the next value of used, and valid in the same cycle as used.
- Read pipeline: an accepted read at edge N gives read_valid=1 and read_data=word in the cycle after edge N+LATENCY-1. That is, LATENCY edges after the request edge, with LATENCY=1 meaning a registered RAM output.
  - Back-to-back accepted reads give back-to-back read_valid.
  - When read_valid=0, read_data holds its last valid value.
- Ordering: strict FIFO order across all wrap-arounds.
- Errors: overflow and underflow remain set until clear_errors=1, which clears them at the next edge. If a new error event and clear_errors occur in the same cycle, the set wins.
- Error events do not affect data, pointers or used.
- Parameter check: an elaboration-time check rejects a non-power-of-two FIFO_DEPTH or a LATENCY outside 1..8.

Test Plan:
1. Reset → all outputs at their reset values. Release, then 40 writes of 0..39 at depth 32 → full=1 after 32 accepted writes; almost_full=1 from used=29; overflow=1 after write 33; used=32.
2. From full, 40 reads → read_valid pulses 32 times with data 0..31, each 3 cycles after its read; empty=1 and almost_empty=1 from used<=3; underflow=1; used=0.
3. Pointer wrap: repeat scenario 1/2 with data 32..63 (wrap MSB=1) → data order intact. clear_errors pulse → overflow=0, underflow=0.
4. Preload 3 words (48..50), then 67 cycles of simultaneous read+write of 51.. → used stays 3; read_valid continuous; output sequence 48,49,50,51,... with no gaps.
5. Empty FIFO, simultaneous read+write of 128.. with a 2-cycle gap between operations → each read rejected while empty; the word appears only after the next read; underflow=1; no data lost or duplicated.
6. Write 10 words, issue 2 reads, assert reset 1 cycle later → read_valid never asserts for the in-flight words; after release used=0, empty=1, and a new write/read returns the new data.
